// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared types and constants for the memory controller:
//                controller state encoding, bus owner encoding, LSB access
//                length codes and the IO-region address tag.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // Controller state. DONE is a single-cycle acknowledge state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Which requester currently owns the memory bus.
    typedef enum logic {
        OWN_IC  = 1'b0,
        OWN_LSB = 1'b1
    } owner_e;

    // lsb_len codes; the unused code 2'b11 behaves as a word access.
    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    // Default addr[17:16] tag for the memory-mapped IO region.
    localparam logic [1:0] IO_ADDR_HI_DEF = 2'b11;

    // Default i-cache line size in bytes.
    localparam int IC_LINE_BYTES_DEF = 8;

    // Number of bus bytes moved for an LSB access of the given length code.
    function automatic logic [3:0] lsb_len_bytes(input logic [1:0] len);
        logic [3:0] n;
        case (len)
            LEN_BYTE: n = 4'd1;
            LEN_HALF: n = 4'd2;
            LEN_WORD: n = 4'd4;
            default:  n = 4'd4;
        endcase
        return n;
    endfunction

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Arbitrates the i-cache line fetch port and the load/store
//                buffer port onto an 8-bit single-port RAM/IO bus, moving one
//                byte per cycle, little-endian.
//  Ports       : clk_in, rst_in (async, active high), rdy_in (pause when low),
//                clear_signal (flush: aborts fetches and loads),
//                ic_signal/ic_addr -> ic_done/ic_data (line fetch),
//                lsb_signal/lsb_wr/lsb_len/lsb_addr/lsb_wdata
//                  -> lsb_done/lsb_rdata (byte/half/word load or store),
//                mem_din/mem_dout/mem_a/mem_wr (RAM bus, read data one cycle
//                after its address), io_buffer_full (stalls IO writes).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         IC_LINE_BYTES = IC_LINE_BYTES_DEF,
    parameter logic [1:0] IO_ADDR_HI    = IO_ADDR_HI_DEF
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       clear_signal,

    input  logic                       ic_signal,
    input  logic [31:0]                ic_addr,
    output logic                       ic_done,
    output logic [8*IC_LINE_BYTES-1:0] ic_data,

    input  logic                       lsb_signal,
    input  logic                       lsb_wr,
    input  logic [1:0]                 lsb_len,
    input  logic [31:0]                lsb_addr,
    input  logic [31:0]                lsb_wdata,
    output logic                       lsb_done,
    output logic [31:0]                lsb_rdata,

    input  logic [7:0]                 mem_din,
    output logic [7:0]                 mem_dout,
    output logic [31:0]                mem_a,
    output logic                       mem_wr,
    input  logic                       io_buffer_full
);

    localparam logic [3:0] IC_NBYTES = 4'(IC_LINE_BYTES);

    state_e                     state_q,     state_d;
    owner_e                     owner_q,     owner_d;
    logic [3:0]                 nbytes_q,    nbytes_d;   // bytes in this transfer
    logic [3:0]                 cnt_q,       cnt_d;      // bytes issued so far
    logic [31:0]                base_q,      base_d;
    logic [31:0]                wdata_q,     wdata_d;
    logic [8*IC_LINE_BYTES-1:0] line_q,      line_d;     // read assembly buffer
    logic [31:0]                prev_addr_q;             // last address put on the bus

    logic [31:0]                w_cur_addr;
    logic [3:0]                 w_cap_idx;
    logic                       w_io_stall;

    assign w_cur_addr = base_q + {28'd0, cnt_q};
    // Data returning now belongs to the address issued one cycle earlier.
    assign w_cap_idx  = cnt_q - 4'd1;
    assign w_io_stall = (w_cur_addr[17:16] == IO_ADDR_HI) && io_buffer_full;

    assign ic_data   = line_q;
    // Line buffer is cleared on every read accept, so the upper bytes of a
    // short load are already zero.
    assign lsb_rdata = line_q[31:0];

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        nbytes_d = nbytes_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        line_d   = line_q;
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        ic_done  = 1'b0;
        lsb_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                if (lsb_signal) begin
                    owner_d  = OWN_LSB;
                    base_d   = lsb_addr;
                    wdata_d  = lsb_wdata;
                    nbytes_d = lsb_len_bytes(lsb_len);
                    if (lsb_wr) begin
                        // Keep the previous load result visible during a store.
                        state_d = ST_WRITE;
                    end else begin
                        line_d  = '0;
                        state_d = ST_READ;
                    end
                end else if (ic_signal) begin
                    owner_d  = OWN_IC;
                    base_d   = ic_addr;
                    nbytes_d = IC_NBYTES;
                    line_d   = '0;
                    state_d  = ST_READ;
                end
            end

            ST_READ: begin
                if (clear_signal) begin
                    // Fetches and loads are speculative: drop them silently.
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q != 4'd0) begin
                        line_d[8*int'(w_cap_idx) +: 8] = mem_din;
                    end
                    if (cnt_q == nbytes_q) begin
                        state_d = ST_DONE;
                    end else begin
                        mem_a = w_cur_addr;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            ST_WRITE: begin
                // Stores are committed: clear_signal is deliberately ignored.
                mem_a    = w_cur_addr;
                mem_dout = wdata_q[8*int'(cnt_q[1:0]) +: 8];
                if (!w_io_stall) begin
                    mem_wr = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == nbytes_q) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // Requests are not examined here so a requester that drops its
                // signal one cycle after the pulse is never served twice.
                ic_done  = (owner_q == OWN_IC);
                lsb_done = (owner_q == OWN_LSB);
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!rdy_in) begin
            // Re-present the previous address so the RAM keeps returning the
            // byte that will be captured on the resume cycle.
            mem_a    = prev_addr_q;
            mem_wr   = 1'b0;
            ic_done  = 1'b0;
            lsb_done = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IC;
            nbytes_q    <= 4'd0;
            cnt_q       <= 4'd0;
            base_q      <= 32'd0;
            wdata_q     <= 32'd0;
            line_q      <= '0;
            prev_addr_q <= 32'd0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            nbytes_q    <= nbytes_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            line_q      <= line_d;
            prev_addr_q <= mem_a;
        end
    end

endmodule : mem_ctrl
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ctrl
//  Description : Self-checking bench for mem_ctrl with a byte RAM model,
//                directed vector table, hand-written corner sequences and
//                randomized traffic against a memory-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_signal;
    logic        ic_signal;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic [63:0] ic_data;
    logic        lsb_signal;
    logic        lsb_wr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int total = 0;
    int bad   = 0;

    mem_ctrl dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .clear_signal  (clear_signal),
        .ic_signal     (ic_signal),
        .ic_addr       (ic_addr),
        .ic_done       (ic_done),
        .ic_data       (ic_data),
        .lsb_signal    (lsb_signal),
        .lsb_wr        (lsb_wr),
        .lsb_len       (lsb_len),
        .lsb_addr      (lsb_addr),
        .lsb_wdata     (lsb_wdata),
        .lsb_done      (lsb_done),
        .lsb_rdata     (lsb_rdata),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Preloaded RAM contents: 0x1000..0x100F hold 0x00..0x0F, the rest a hash.
    function automatic logic [7:0] init_byte(input logic [17:0] a);
        logic [31:0] t;
        if (a >= 18'h01000 && a <= 18'h0100F) return {4'h0, a[3:0]};
        t = {14'd0, a} * 32'd7 + 32'd3;
        return t[7:0];
    endfunction

    // ---------------- RAM model (18-bit aliased byte array) -----------------
    logic [7:0] ram_d [0:262143];
    bit         ram_v [0:262143];
    int         wr_count = 0;

    always @(posedge clk_in) begin
        if (mem_wr) begin
            ram_d[mem_a[17:0]] <= mem_dout;
            ram_v[mem_a[17:0]] <= 1'b1;
            wr_count           <= wr_count + 1;
        end
        mem_din <= ram_v[mem_a[17:0]] ? ram_d[mem_a[17:0]] : init_byte(mem_a[17:0]);
    end

    // ---------------- reference memory model --------------------------------
    logic [7:0] model_mem [0:262143];
    bit         model_v   [0:262143];

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        return model_v[a[17:0]] ? model_mem[a[17:0]] : init_byte(a[17:0]);
    endfunction

    function automatic logic [63:0] model_load(input logic [31:0] a, input int n);
        logic [63:0] r;
        logic [31:0] aj;
        r = 64'd0;
        for (int j = 0; j < n; j++) begin
            aj = a + 32'(j);
            r  = r | ({56'd0, model_rd(aj)} << (8 * j));
        end
        return r;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input int n);
        logic [31:0] aj;
        for (int j = 0; j < n; j++) begin
            aj = a + 32'(j);
            model_mem[aj[17:0]] = d[8*j +: 8];
            model_v[aj[17:0]]   = 1'b1;
        end
    endtask

    function automatic int op_bytes(input bit is_ic, input logic [1:0] len);
        if (is_ic) return 8;
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drop_reqs();
        ic_signal  = 1'b0;
        lsb_signal = 1'b0;
        lsb_wr     = 1'b0;
    endtask

    // One transaction from the requester's point of view. Called at a negedge
    // with the controller idle. Done must appear in the Nth rdy-high cycle
    // after acceptance (N = bytes+2 for reads, bytes+1 for writes).
    task automatic run_op(input bit is_ic, input bit wr, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pmask,
                          output logic [63:0] got, output int done_cyc);
        int  n, need, active;
        bit  acc, seen, exp_done;
        logic act_done, oth_done;
        n        = op_bytes(is_ic, len);
        need     = wr ? n + 1 : n + 2;
        acc      = 1'b0;
        seen     = 1'b0;
        active   = 0;
        done_cyc = -1;
        got      = 64'd0;
        ic_signal  = is_ic;
        ic_addr    = addr;
        lsb_signal = !is_ic;
        lsb_wr     = wr;
        lsb_len    = len;
        lsb_addr   = addr;
        lsb_wdata  = wdata;
        for (int c = 0; c < 64 && !seen; c++) begin
            rdy_in = (c < 32) ? !pmask[c] : 1'b1;
            #1;
            if (acc && rdy_in) active++;
            if (!rdy_in) chk("pause_mem_wr", 64'(mem_wr), 64'd0);
            exp_done = acc && rdy_in && (active == need);
            act_done = is_ic ? ic_done : lsb_done;
            oth_done = is_ic ? lsb_done : ic_done;
            if (exp_done || act_done === 1'b1) begin
                chk(is_ic ? "ic_done_timing" : "lsb_done_timing", 64'(act_done), 64'(exp_done));
                chk("other_done", 64'(oth_done), 64'd0);
                seen     = 1'b1;
                done_cyc = c;
                got      = is_ic ? ic_data : {32'd0, lsb_rdata};
                drop_reqs();
            end
            if (rdy_in && !acc) acc = 1'b1;
            @(negedge clk_in);
        end
        if (!seen) chk("op_timeout", 64'd0, 64'd1);
        // Cycle after the pulse: back in IDLE, requests already withdrawn.
        rdy_in = 1'b1;
        #1;
        chk("idle_after_done", {31'd0, ic_done, lsb_done, mem_wr, mem_a}, 64'd0);
        @(negedge clk_in);
    endtask

    typedef struct {
        bit          is_ic;
        bit          wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [63:0] exp_data;
        int          exp_cyc;
    } vec_t;

    vec_t        vecs [12];
    logic [63:0] got;
    int          dc;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0; io_buffer_full = 1'b0;
        ic_signal = 1'b0; ic_addr = 32'd0; lsb_signal = 1'b0; lsb_wr = 1'b0;
        lsb_len = 2'b00; lsb_addr = 32'd0; lsb_wdata = 32'd0;

        vecs[0]  = '{1'b1, 1'b0, 2'b00, 32'h0000_1000, 32'h0, 64'h0706050403020100, 10};
        vecs[1]  = '{1'b0, 1'b0, 2'b10, 32'h0000_1004, 32'h0, 64'h07060504, 6};
        vecs[2]  = '{1'b0, 1'b0, 2'b01, 32'h0000_1002, 32'h0, 64'h0302, 4};
        vecs[3]  = '{1'b0, 1'b0, 2'b00, 32'h0000_100F, 32'h0, 64'h0F, 3};
        vecs[4]  = '{1'b0, 1'b0, 2'b11, 32'h0000_1008, 32'h0, 64'h0B0A0908, 6};
        vecs[5]  = '{1'b0, 1'b1, 2'b01, 32'h0000_2001, 32'hAABBCCDD, 64'h0, 3};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 32'h0000_2002, 32'h0, 64'hCC, 3};
        vecs[7]  = '{1'b0, 1'b0, 2'b10, 32'h0000_2000, 32'h0, 64'h18CCDD03, 6};
        vecs[8]  = '{1'b0, 1'b1, 2'b10, 32'h0000_2010, 32'h11223344, 64'h0, 5};
        vecs[9]  = '{1'b0, 1'b0, 2'b10, 32'h0000_2010, 32'h0, 64'h11223344, 6};
        vecs[10] = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, 64'h0A03FCF5, 6};
        vecs[11] = '{1'b1, 1'b0, 2'b00, 32'h0000_1008, 32'h0, 64'h0F0E0D0C0B0A0908, 10};

        // Reset values
        #1;
        chk("reset_outputs", {29'd0, ic_done, lsb_done, mem_wr, mem_a}, 64'd0);
        chk("reset_mem_dout", 64'(mem_dout), 64'd0);
        chk("reset_ic_data", ic_data, 64'd0);
        chk("reset_lsb_rdata", 64'(lsb_rdata), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].is_ic, vecs[i].wr, vecs[i].len, vecs[i].addr, vecs[i].wdata,
                   32'd0, got, dc);
            chk($sformatf("vec%0d_done_cycle", i), 64'(dc), 64'(vecs[i].exp_cyc));
            if (vecs[i].wr)
                model_store(vecs[i].addr, vecs[i].wdata, op_bytes(1'b0, vecs[i].len));
            else
                chk($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
        end

        // Simultaneous requests: LSB first, then the held i-cache fetch.
        ic_signal = 1'b1; ic_addr = 32'h1008;
        lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b10; lsb_addr = 32'h1004;
        for (int c = 0; c <= 18; c++) begin
            #1;
            chk($sformatf("arb_lsb_done_c%0d", c), 64'(lsb_done), 64'(c == 6));
            chk($sformatf("arb_ic_done_c%0d", c), 64'(ic_done), 64'(c == 17));
            if (c == 6) begin
                chk("arb_lsb_rdata", 64'(lsb_rdata), 64'h07060504);
                lsb_signal = 1'b0;
            end
            if (c == 17) begin
                chk("arb_ic_data", ic_data, 64'h0F0E0D0C0B0A0908);
                ic_signal = 1'b0;
            end
            @(negedge clk_in);
        end

        // IO stall: byte store to the IO region while the UART buffer is full.
        begin
            int wc0;
            wc0 = wr_count;
            io_buffer_full = 1'b1;
            lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'b00;
            lsb_addr = 32'h0003_0000; lsb_wdata = 32'h0000_005A;
            for (int c = 0; c <= 8; c++) begin
                if (c == 6) io_buffer_full = 1'b0;
                #1;
                if (c >= 1 && c <= 5) chk($sformatf("io_stall_wr_c%0d", c), 64'(mem_wr), 64'd0);
                if (c == 6) chk("io_write", {23'd0, mem_wr, mem_dout, mem_a}, {23'd0, 1'b1, 8'h5A, 32'h0003_0000});
                chk($sformatf("io_done_c%0d", c), 64'(lsb_done), 64'(c == 7));
                if (c == 7) drop_reqs();
                @(negedge clk_in);
            end
            chk("io_write_count", 64'(wr_count - wc0), 64'd1);
            model_store(32'h0003_0000, 32'h5A, 1);
            run_op(1'b0, 1'b0, 2'b00, 32'h0003_0000, 32'd0, 32'd0, got, dc);
            chk("io_readback", got, 64'h5A);
        end

        // Pause 3 cycles mid-fetch: same line, pulse 3 cycles later.
        run_op(1'b1, 1'b0, 2'b00, 32'h1000, 32'd0, 32'h0000_0038, got, dc);
        chk("pause_done_cycle", 64'(dc), 64'd13);
        chk("pause_line", got, 64'h0706050403020100);

        // Clear at cycle 4 of a fetch: no pulse, idle (and accepting) next cycle.
        ic_signal = 1'b1; ic_addr = 32'h1000;
        for (int c = 0; c <= 12; c++) begin
            clear_signal = (c == 4);
            if (c == 5) begin
                ic_signal = 1'b0;
                lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b00; lsb_addr = 32'h100F;
            end
            #1;
            if (c == 4) chk("clear_mem_wr", 64'(mem_wr), 64'd0);
            chk($sformatf("clear_ic_done_c%0d", c), 64'(ic_done), 64'd0);
            chk($sformatf("clear_lsb_done_c%0d", c), 64'(lsb_done), 64'(c == 8));
            if (c == 8) begin
                chk("clear_then_lb", 64'(lsb_rdata), 64'h0F);
                drop_reqs();
            end
            @(negedge clk_in);
        end

        // Clear during a word store: store still completes.
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'b10;
        lsb_addr = 32'h2020; lsb_wdata = 32'hCAFEBABE;
        for (int c = 0; c <= 7; c++) begin
            clear_signal = (c == 2);
            #1;
            if (c == 2) chk("clear_sw_mem_wr", 64'(mem_wr), 64'd1);
            chk($sformatf("clear_sw_done_c%0d", c), 64'(lsb_done), 64'(c == 5));
            if (c == 5) drop_reqs();
            @(negedge clk_in);
        end
        model_store(32'h2020, 32'hCAFEBABE, 4);
        run_op(1'b0, 1'b0, 2'b10, 32'h2020, 32'd0, 32'd0, got, dc);
        chk("clear_sw_readback", got, 64'hCAFEBABE);

        // Randomized traffic with random pauses against the memory model.
        for (int i = 0; i < 40; i++) begin
            int          kind;
            bit          r_ic, r_wr;
            logic [1:0]  r_len;
            logic [31:0] r_addr, r_wdata, r_pm;
            kind    = int'($urandom_range(0, 2));
            r_ic    = (kind == 0);
            r_wr    = (kind == 2);
            r_len   = 2'($urandom_range(0, 3));
            r_addr  = 32'h4000 + 32'($urandom_range(0, 255));
            if (r_ic) r_addr[2:0] = 3'd0;
            r_wdata = $urandom;
            r_pm    = $urandom & $urandom & 32'h0000_FFFF;
            run_op(r_ic, r_wr, r_len, r_addr, r_wdata, r_pm, got, dc);
            if (r_wr)
                model_store(r_addr, r_wdata, op_bytes(1'b0, r_len));
            else
                chk($sformatf("rand%0d_data", i), got, model_load(r_addr, op_bytes(r_ic, r_len)));
        end

        // Asynchronous reset in the middle of a store.
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'b10;
        lsb_addr = 32'h2030; lsb_wdata = 32'h01020304;
        @(negedge clk_in);
        @(negedge clk_in);
        #1;
        chk("pre_reset_mem_wr", 64'(mem_wr), 64'd1);
        rst_in = 1'b1;
        #1;
        chk("async_reset_outputs", {29'd0, ic_done, lsb_done, mem_wr, mem_a}, 64'd0);
        chk("async_reset_dout", 64'(mem_dout), 64'd0);
        chk("async_reset_rdata", {lsb_rdata, 32'd0} | 64'(ic_data != 64'd0), 64'd0);
        drop_reqs();
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        #1;
        chk("post_reset_idle", {31'd0, ic_done, lsb_done, mem_wr, mem_a}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_ctrl
`default_nettype wire
